// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit, fixed XLEN+1 cycle latency.
package riscv_pkg;
  localparam int XLEN = 32;
endpackage

module md_unit #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] f_q, f_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q;
  logic neg_q, neg_d, sa, sb;
  logic [XLEN-1:0] ma, mb, fix_val;
  logic [XLEN:0] sum, rem, trial;
  logic [2*XLEN-1:0] prod;
  assign busy = st_q != IDLE;
  assign done = st_q == FIX && !flush;
  assign Result = done ? fix_val : res_q;
  // hi:lo is the product for multiplies and remainder:quotient for divides
  always_comb begin
    sa = (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110}) && A[XLEN-1];
    sb = (funct3 inside {3'b001, 3'b100, 3'b110}) && B[XLEN-1];
    ma = sa ? -A : A;
    mb = sb ? -B : B;
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem = {hi_q, lo_q[XLEN-1]};
    trial = rem - {1'b0, m_q};
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    fix_val = !f_q[2] ? (f_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
              f_q[1] ? (neg_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
    st_d = st_q;
    cnt_d = cnt_q;
    f_d = f_q;
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    neg_d = neg_q;
    case (st_q)
      IDLE: if (start) begin
        st_d = CALC;
        cnt_d = '0;
        f_d = funct3;
        hi_d = '0;
        lo_d = funct3[2] ? ma : mb;
        m_d = funct3[2] ? mb : ma;
        // a zero divisor keeps the all-ones quotient unsigned
        neg_d = !funct3[2] ? sa ^ sb : funct3[1] ? sa : (sa ^ sb) && (B != '0);
      end
      CALC: if (cnt_q == CW'(XLEN)) st_d = FIX;
      else begin
        cnt_d = cnt_q + CW'(1);
        hi_d = !f_q[2] ? sum[XLEN:1] : trial[XLEN] ? rem[XLEN-1:0] : trial[XLEN-1:0];
        lo_d = !f_q[2] ? {sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], !trial[XLEN]};
      end
      FIX: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (flush) st_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      f_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      f_q <= f_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      neg_q <= neg_d;
      res_q <= done ? fix_val : res_q;
    end
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL be parameterised only by XLEN from riscv_pkg (32 default), with no local parameters exposed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: start  input  1  request; accepted only in IDLE.
REQ-006 Port: funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: A  input  XLEN  operand rs1.
REQ-008 Port: B  input  XLEN  operand rs2.
REQ-009 Port: flush  input  1  abort any in-flight operation.
REQ-010 Port: busy  output  1  operation in flight; pipeline stall source.
REQ-011 Port: done  output  1  one-cycle result-valid pulse.
REQ-012 Port: Result  output  XLEN  result, held until the next done.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, FIX.
REQ-014 Transitions SHALL be:
- IDLE->CALC on start && !flush.
- CALC->FIX after XLEN iterations.
- FIX->IDLE unconditionally.
- Any state->IDLE on flush.
REQ-015 On acceptance, the block SHALL latch funct3, A and B; later changes to the inputs SHALL NOT affect the result.
REQ-016 The block SHALL ignore start when the FSM is not in IDLE; no queueing.
REQ-017 busy SHALL be 1 in CALC and FIX and 0 in IDLE.
REQ-018 With acceptance at edge N, CALC SHALL occupy edges N+1..N+XLEN, and done=1 with valid Result SHALL occur in the FIX cycle after edge N+XLEN+1, for a fixed latency of XLEN+1 cycles for every op.
REQ-019 done SHALL be high for exactly one cycle, coincident with FIX; busy drops the following cycle.
REQ-020 A new start in the cycle after FIX SHALL be accepted.
REQ-021 Multiply SHALL be iterative shift-add on magnitudes, one bit per CALC cycle, into a 2*XLEN product.
- Signed operands (MULH: A,B; MULHSU: A only) are converted to magnitude on acceptance.
- The product is negated in FIX when the operand signs differ.
REQ-022 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-023 Divide SHALL be restoring, one quotient bit per CALC cycle, on magnitudes for DIV/REM.
- FIX negates the quotient if the signs differ.
- FIX negates the remainder if A was negative.
REQ-024 Divide by zero (B==0) SHALL return, with unchanged latency:
- DIV/DIVU: all ones.
- REM/REMU: A.
REQ-025 Signed overflow (DIV/REM, A==1<<(XLEN-1), B==all ones) SHALL return, with unchanged latency:
- DIV: A.
- REM: 0.
REQ-026 flush SHALL take priority over start and over completion; a flush in the FIX cycle forces done=0 and leaves Result at its previous value.
REQ-027 All arithmetic SHALL be modulo 2^XLEN; internal negation SHALL be two's complement.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL go to IDLE with busy=0, done=0, Result=0 and the iteration counter=0.
REQ-029 Reset mid-operation SHALL abandon the operation with no done pulse; reset SHALL have priority over flush and start.

Verification (XLEN=32)
REQ-030 The bench SHALL check MUL: A=7, B=-3, start -> done exactly 33 cycles later, Result=0xFFFFFFEB, busy high for those 33 cycles.
REQ-031 The bench SHALL check MULH and MULHU: A=B=0x80000000 -> MULH Result=0x40000000; MULHU Result=0x40000000; with B=0xFFFFFFFF, MULHSU Result=0x80000000.
REQ-032 The bench SHALL check DIV and REM: A=-7, B=2 -> DIV=0xFFFFFFFD (-3); REM=0xFFFFFFFF (-1); DIVU of 0xFFFFFFF9/2=0x7FFFFFFC.
REQ-033 The bench SHALL check corner cases: DIVU A=5, B=0 -> 0xFFFFFFFF; REMU -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; all with a 33-cycle latency.
REQ-034 The bench SHALL check start while busy: a second start with different operands is ignored and the first result is delivered; then start in the cycle after done is accepted.
REQ-035 The bench SHALL check abort: flush at CALC cycle 10, and separately rst_n=0 at CALC cycle 10 -> no done, busy=0 next cycle, Result unchanged after flush and 0 after reset; then a new MUL 3*4 -> 12.
